// File: rtl/pmod_cond_pkg.sv
// Shared types for the PMOD input conditioner: debounce FSM state encoding
// and the sizing helper for the debounce counter.
package pmod_cond_pkg;

  typedef enum logic [1:0] {
    LOW_STABLE  = 2'd0,
    RISE_CHECK  = 2'd1,
    HIGH_STABLE = 2'd2,
    FALL_CHECK  = 2'd3
  } cond_state_t;

  // Counter only needs to reach cycles-1; never narrower than one bit.
  function automatic int cnt_width(input int cycles);
    if (cycles <= 2) return 1;
    return $clog2(cycles);
  endfunction

endpackage

// File: rtl/sync_ff_chain.sv
// Multi-flop synchroniser for bringing an asynchronous pin into i_SCLK.
// STAGES must be at least 2; q is the last stage.
module sync_ff_chain #(
  parameter int STAGES = 2
) (
  input  logic i_SCLK,
  input  logic i_RESET_SYSB,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain_reg;

  generate
    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
      if (gi == 0) begin : g_first
        always_ff @(posedge i_SCLK or negedge i_RESET_SYSB) begin
          if (!i_RESET_SYSB) chain_reg[gi] <= 1'b0;
          else               chain_reg[gi] <= d;
        end
      end else begin : g_rest
        always_ff @(posedge i_SCLK or negedge i_RESET_SYSB) begin
          if (!i_RESET_SYSB) chain_reg[gi] <= 1'b0;
          else               chain_reg[gi] <= chain_reg[gi-1];
        end
      end
    end
  endgenerate

  assign q = chain_reg[STAGES-1];

endmodule

// File: rtl/pmod_pulse_conditioner.sv
// Synchronises and debounces a raw PMOD pin, producing one-cycle strobes per
// accepted edge, the debounced level and a saturating count of rejected bounces.
module pmod_pulse_conditioner
  import pmod_cond_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int GLITCH_W        = 8
) (
  input  logic                i_SCLK,
  input  logic                i_RESET_SYSB,
  input  logic                i_PMOD1_P1,
  input  logic                i_GLITCH_CLR,
  output logic                o_PULSE,
  output logic                o_FALL,
  output logic                o_LEVEL,
  output logic [GLITCH_W-1:0] o_GLITCH_CNT
);

  localparam int                  CNT_W      = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]    CNT_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [GLITCH_W-1:0] GLITCH_MAX = '1;

  logic                s;
  cond_state_t         state_reg;
  logic [CNT_W-1:0]    cnt_reg;
  logic                pulse_reg;
  logic                fall_reg;
  logic                level_reg;
  logic [GLITCH_W-1:0] glitch_reg;
  logic                glitch_hit;

  sync_ff_chain #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .i_SCLK      (i_SCLK),
    .i_RESET_SYSB(i_RESET_SYSB),
    .d           (i_PMOD1_P1),
    .q           (s)
  );

  // A CHECK state that sees the old level again is a rejected transition.
  always_comb begin
    glitch_hit = 1'b0;
    if ((state_reg == RISE_CHECK && !s) || (state_reg == FALL_CHECK && s))
      glitch_hit = 1'b1;
  end

  always_ff @(posedge i_SCLK or negedge i_RESET_SYSB) begin
    if (!i_RESET_SYSB) begin
      state_reg <= LOW_STABLE;
      cnt_reg   <= '0;
      pulse_reg <= 1'b0;
      fall_reg  <= 1'b0;
      level_reg <= 1'b0;
    end else begin
      pulse_reg <= 1'b0;
      fall_reg  <= 1'b0;
      case (state_reg)
        LOW_STABLE: begin
          if (s) begin
            state_reg <= RISE_CHECK;
            cnt_reg   <= '0;
          end
        end
        RISE_CHECK: begin
          if (!s) begin
            state_reg <= LOW_STABLE;
          end else if (cnt_reg == CNT_LAST) begin
            state_reg <= HIGH_STABLE;
            pulse_reg <= 1'b1;
            level_reg <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        HIGH_STABLE: begin
          if (!s) begin
            state_reg <= FALL_CHECK;
            cnt_reg   <= '0;
          end
        end
        FALL_CHECK: begin
          if (s) begin
            state_reg <= HIGH_STABLE;
          end else if (cnt_reg == CNT_LAST) begin
            state_reg <= LOW_STABLE;
            fall_reg  <= 1'b1;
            level_reg <= 1'b0;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        default: state_reg <= LOW_STABLE;
      endcase
    end
  end

  // Clear has priority over a same-cycle increment; count holds at all-ones.
  always_ff @(posedge i_SCLK or negedge i_RESET_SYSB) begin
    if (!i_RESET_SYSB)                          glitch_reg <= '0;
    else if (i_GLITCH_CLR)                      glitch_reg <= '0;
    else if (glitch_hit && glitch_reg != GLITCH_MAX) glitch_reg <= glitch_reg + 1'b1;
  end

  assign o_PULSE      = pulse_reg;
  assign o_FALL       = fall_reg;
  assign o_LEVEL      = level_reg;
  assign o_GLITCH_CNT = glitch_reg;

endmodule

// File: tb/tb_pmod_pulse_conditioner.sv
// Directed scenarios plus randomized pin activity, checked every cycle against
// a run-length model of the synchronised, debounced pin.
module tb_pmod_pulse_conditioner;

  localparam int SYNC = 2;
  localparam int DEB  = 4;
  localparam int GW   = 8;
  localparam int GMAX = (1 << GW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          pin = 1'b0;
  logic          clr = 1'b0;
  logic          o_pulse;
  logic          o_fall;
  logic          o_level;
  logic [GW-1:0] o_gcnt;

  int total = 0;
  int bad   = 0;
  int pulse_total = 0;

  always #5 clk = ~clk;

  pmod_pulse_conditioner #(
    .SYNC_STAGES    (SYNC),
    .DEBOUNCE_CYCLES(DEB),
    .GLITCH_W       (GW)
  ) dut (
    .i_SCLK      (clk),
    .i_RESET_SYSB(rst_n),
    .i_PMOD1_P1  (pin),
    .i_GLITCH_CLR(clr),
    .o_PULSE     (o_pulse),
    .o_FALL      (o_fall),
    .o_LEVEL     (o_level),
    .o_GLITCH_CNT(o_gcnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: pin delayed by SYNC edges, then accepted once it has differed
  // from the debounced level on DEB+1 consecutive edges; a shorter run is a glitch.
  bit m_sync [SYNC];
  bit m_lvl;
  int m_run;
  int m_gl;
  bit m_p;
  bit m_f;
  bit m_s;
  bit m_inc;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC; i++) m_sync[i] = 1'b0;
      m_lvl = 1'b0; m_run = 0; m_gl = 0; m_p = 1'b0; m_f = 1'b0;
    end else begin
      m_s = m_sync[SYNC-1];
      for (int i = SYNC-1; i > 0; i--) m_sync[i] = m_sync[i-1];
      m_sync[0] = pin;
      m_p = 1'b0; m_f = 1'b0; m_inc = 1'b0;
      if (m_s != m_lvl) begin
        m_run++;
        if (m_run == DEB + 1) begin
          m_lvl = m_s;
          m_run = 0;
          if (m_s) m_p = 1'b1; else m_f = 1'b1;
        end
      end else begin
        if (m_run > 0) m_inc = 1'b1;
        m_run = 0;
      end
      if (clr) m_gl = 0;
      else if (m_inc && m_gl < GMAX) m_gl++;
    end
  end

  always @(posedge clk) begin
    #3;
    check("pulse", {31'd0, o_pulse}, {31'd0, m_p});
    check("fall",  {31'd0, o_fall},  {31'd0, m_f});
    check("level", {31'd0, o_level}, {31'd0, m_lvl});
    check("gcnt",  {24'd0, o_gcnt},  m_gl);
  end

  always @(posedge clk) begin
    #1;
    if (o_pulse === 1'b1) pulse_total++;
  end

  task automatic hold(input logic v, input int n);
    @(negedge clk);
    pin = v;
    repeat (n - 1) @(negedge clk);
  endtask

  // Edges counted from the first posedge after the caller's negedge change.
  task automatic measure(input bit want_fall, output int lat);
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if ((want_fall ? o_fall : o_pulse) === 1'b1) begin
        lat = i;
        break;
      end
    end
  endtask

  int lat;
  int start;
  logic [3:0] press_cnt;

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_pulse", {31'd0, o_pulse}, 0);
    check("rst_level", {31'd0, o_level}, 0);
    check("rst_gcnt",  {24'd0, o_gcnt},  0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    start = pulse_total;
    pin = 1'b1;
    measure(1'b0, lat);
    check("press_lat", lat, 7);
    check("press_level", {31'd0, o_level}, 1);
    repeat (13) @(negedge clk);
    check("press_gcnt", {24'd0, o_gcnt}, 0);
    check("press_count", pulse_total - start, 1);
    $display("press: latency %0d edges", lat);

    @(negedge clk);
    pin = 1'b0;
    measure(1'b1, lat);
    check("release_lat", lat, 7);
    check("release_level", {31'd0, o_level}, 0);
    repeat (15) @(negedge clk);
    check("release_nopulse", pulse_total - start, 1);
    $display("release: latency %0d edges", lat);

    start = pulse_total;
    hold(1'b1, 2); hold(1'b0, 1); hold(1'b1, 2); hold(1'b0, 10);
    check("bounce_gcnt", {24'd0, o_gcnt}, 2);
    check("bounce_nopulse", pulse_total - start, 0);
    check("bounce_level", {31'd0, o_level}, 0);
    $display("bounce: glitch count %0d", o_gcnt);

    for (int i = 0; i < 300; i++) begin
      hold(1'b1, 1); hold(1'b0, 3);
    end
    check("sat_gcnt", {24'd0, o_gcnt}, GMAX);
    @(negedge clk);
    clr = 1'b1;
    hold(1'b1, 1); hold(1'b0, 3);
    @(negedge clk);
    clr = 1'b0;
    repeat (2) @(negedge clk);
    check("clr_gcnt", {24'd0, o_gcnt}, 0);
    $display("saturate/clear: glitch count %0d", o_gcnt);

    start = pulse_total;
    @(negedge clk);
    pin = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    check("rst_mid_nopulse", pulse_total - start, 0);
    repeat (2) begin
      @(posedge clk);
      #1;
      check("rst_mid_out", {o_pulse, o_fall, o_level, o_gcnt}, 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    measure(1'b0, lat);
    check("rst_mid_lat", lat, 7);
    check("rst_mid_count", pulse_total - start, 1);
    $display("reset mid-debounce: latency after release %0d", lat);
    hold(1'b0, 20);

    start = pulse_total;
    for (int i = 0; i < 5; i++) begin
      hold(1'b1, 12); hold(1'b0, 12);
    end
    press_cnt = 4'(pulse_total - start);
    check("b2b_count", {28'd0, press_cnt}, 5);
    $display("back-to-back: %0d presses counted", press_cnt);

    for (int seg = 0; seg < 80; seg++) begin
      clr = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 19) == 0) begin
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
      end
      hold(1'($urandom_range(0, 1)), int'($urandom_range(1, 9)));
      $display("random seg %0d: pin=%0d level=%0d gcnt=%0d", seg, pin, o_level, o_gcnt);
    end
    clr = 1'b0;
    hold(1'b0, 20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pmod_pulse_conditioner.md
Name: pmod_pulse_conditioner

Overview:
Upstream front-end for the LED pulse counter. It synchronises the raw asynchronous PMOD pin into the i_SCLK domain and debounces it with a 4-state FSM. It emits exactly one single-cycle o_PULSE per confirmed rising edge, so the downstream counter advances once per physical press or edge, not once per high cycle. It also reports the debounced level, falling-edge strobes and a saturating glitch count for bring-up.

Parameters:
SYNC_STAGES, 2, number of synchroniser flops (legal: >=2).
DEBOUNCE_CYCLES, 50000, consecutive stable synchronised cycles needed to accept a level change (legal: >=1; 1 ms at 50 MHz).
GLITCH_W, 8, width of the saturating glitch counter.

Ports:
i_SCLK  input  1  system clock, all logic on rising edge.
i_RESET_SYSB  input  1  asynchronous active-low reset.
i_PMOD1_P1  input  1  raw asynchronous pin; bouncy, unsynchronised.
i_GLITCH_CLR  input  1  synchronous clear of o_GLITCH_CNT.
o_PULSE  output  1  one-cycle strobe on each accepted rising edge; feeds the counter's pulse input.
o_FALL  output  1  one-cycle strobe on each accepted falling edge.
o_LEVEL  output  1  debounced level.
o_GLITCH_CNT  output  GLITCH_W  count of rejected transitions, saturating.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low, named i_SCLK / i_RESET_SYSB. While reset is low, all sync flops are 0, state is LOW_STABLE, the debounce count is 0, o_PULSE=0, o_FALL=0, o_LEVEL=0, o_GLITCH_CNT=0.
- Reset mid-operation: everything returns immediately to reset values. A pending debounce is abandoned with no strobe. If the pin is high after reset release, it is treated as a new rising edge and produces one o_PULSE after full latency.
- Synchroniser: SYNC_STAGES-deep shift chain. s = last stage. Only s feeds the FSM.
- Debounce count: localparam width max(1, $clog2(DEBOUNCE_CYCLES)).
- FSM states (encoding held in the package): LOW_STABLE, RISE_CHECK, HIGH_STABLE, FALL_CHECK.
- LOW_STABLE: s=1 -> RISE_CHECK, count<=0.
- RISE_CHECK:
  - s=0 -> LOW_STABLE, glitch+1.
  - s=1 and count==DEBOUNCE_CYCLES-1 -> HIGH_STABLE, o_PULSE<=1.
  - Otherwise count+1.
- HIGH_STABLE: s=0 -> FALL_CHECK, count<=0.
- FALL_CHECK:
  - s=1 -> HIGH_STABLE, glitch+1.
  - s=0 and count==DEBOUNCE_CYCLES-1 -> LOW_STABLE, o_FALL<=1.
  - Otherwise count+1.
- Output registers:
  - o_PULSE and o_FALL are registered and high for exactly one cycle.
  - o_LEVEL=1 in HIGH_STABLE and FALL_CHECK, 0 otherwise; registered, changes on the same edge as o_PULSE/o_FALL.
- Latency: number rising edges from the first edge that samples the new pin value as edge 1. o_PULSE is high after edge SYNC_STAGES+1+DEBOUNCE_CYCLES. Example: 2/4 gives edge 7.
- Strobe spacing: consecutive o_PULSE strobes are separated by at least 2*DEBOUNCE_CYCLES+2 cycles, so o_PULSE and o_FALL are never high together.
- Glitch counter: saturates at 2^GLITCH_W-1 with no wrap. If i_GLITCH_CLR and an increment occur in the same cycle, clear wins and the result is 0.
- DEBOUNCE_CYCLES=1: a level is accepted after a single confirming cycle in the CHECK state.

Decomposition:
- Package pmod_cond_pkg: state type/encoding (4 states, 2 bits) and the function computing the debounce count width.
- Sub-module sync_ff_chain (parameter STAGES; ports i_SCLK, i_RESET_SYSB, d, q), reusable for other PMOD inputs.
- The FSM, counters and output registers stay in the top module.

Test Plan:
All scenarios use SYNC_STAGES=2, DEBOUNCE_CYCLES=4, GLITCH_W=8.
- Clean press: pin 0->1 held 20 cycles -> o_PULSE high only after edge 7, o_LEVEL=1 from edge 7, o_GLITCH_CNT=0.
- Clean release: from the accepted-high state, pin 1->0 held -> o_FALL one cycle after edge 7 of the release, o_LEVEL=0 from the same edge, no o_PULSE.
- Bounce: pin high 2 cycles, low 1, high 2, low 10 -> no o_PULSE, o_GLITCH_CNT=2, o_LEVEL stays 0.
- Saturation/clear: 300 rejected short glitches -> o_GLITCH_CNT=255. Then assert i_GLITCH_CLR in the same cycle as a glitch -> o_GLITCH_CNT=0.
- Reset mid-debounce: pin high, assert reset at edge 5, release at edge 8 with pin still high -> no strobe before reset, all outputs 0 during reset, one o_PULSE exactly 7 edges after release.
- Back-to-back presses: 5 clean presses (high 12, low 12 cycles each) -> exactly 5 o_PULSE strobes, each one cycle wide, so a downstream 4-bit counter reads 5.
